instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the multicycle RV64 core. Owns the PC and the instruction register, and runs a request/ready handshake to the instruction memory.
- Feeds the control unit its 32-bit instruction word and a one-cycle instr_valid pulse.
- Applies PC increment and branch redirects from the control unit's PCWrite/PCWriteCond/BranchOp/PCSrc outputs. Flags misaligned fetches and memory timeouts.

Parameters:
- XLEN, 64, PC/target width
- RESET_PC, 64'h0, PC value loaded on reset
- TIMEOUT_CYCLES, 16, max cycles in WAIT before timeout fault (>=2)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  control requests next instruction (driven from LoadIR phase)
- pc_write  in  1  unconditional PC load from branch_target
- pc_write_cond  in  1  conditional PC load (branch)
- branch_op  in  1  0=BEQ (take on alu_zero), 1=BNE (take on !alu_zero)
- pc_src  in  1  1=branch_target, 0=pc+4 on pc_write
- alu_zero  in  1  ALU zero flag for branch compare
- branch_target  in  XLEN  redirect address
- imem_addr  out  XLEN  instruction memory address
- imem_rd  out  1  read request, held until imem_ready or abort
- imem_rdata  in  32  read data, valid when imem_rd && imem_ready
- imem_ready  in  1  memory completes read this cycle
- instruction  out  32  instruction register contents
- instr_valid  out  1  one-cycle pulse: new instruction latched
- pc  out  XLEN  current PC (next fetch address)
- instr_pc  out  XLEN  address of the instruction currently in the instruction register
- fetch_busy  out  1  FSM in WAIT
- fetch_err  out  1  sticky fault flag
- err_cause  out  2  01=misaligned, 10=timeout, 00=none; set only on the first fault

Behaviour:
- Reset (sync, active-high) values:
  - pc=RESET_PC, instr_pc=RESET_PC, instruction=32'h0000_0013 (NOP).
  - instr_valid=0, imem_rd=0, fetch_busy=0, fetch_err=0, err_cause=00, timer=0, state=IDLE.
  - Reset mid-WAIT drops imem_rd the next cycle; the pending response is ignored.
- FSM states: IDLE, WAIT.
- IDLE:
  - On fetch_req with pc[1:0]==0: assert imem_rd with imem_addr=pc registered, go to WAIT, clear the timer.
  - On fetch_req with pc[1:0]!=0: no request, stay in IDLE, set fetch_err (cause 01 if none recorded yet).
- WAIT:
  - imem_rd=1 and imem_addr stable; the timer increments each cycle.
  - On imem_ready: instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^XLEN, wraps), instr_valid=1 next cycle for exactly 1 cycle, return to IDLE, imem_rd=0.
  - Latency: fetch_req at cycle 0, ready at cycle k>=1 gives instr_valid at cycle k+1.
  - Timeout: timer reaches TIMEOUT_CYCLES without ready -> imem_rd=0, go to IDLE, set fetch_err (cause 10 if none). pc and instruction are unchanged.
  - fetch_req during WAIT is ignored.
- Redirect:
  - redirect = pc_write | (pc_write_cond & (alu_zero ^ branch_op)).
  - Target = pc_src ? branch_target : pc+4.
  - pc_write_cond taken always uses branch_target.
- Redirect in IDLE: pc<=target next cycle.
- Redirect in WAIT aborts the fetch:
  - pc<=target, state<=IDLE, imem_rd=0 next cycle.
  - imem_ready that same cycle is discarded: no instr_valid, instruction unchanged.
- Redirect and fetch_req in the same IDLE cycle: redirect wins; fetch_req is dropped and the control re-requests.
- fetch_err/err_cause are cleared only by reset. Later faults do not overwrite err_cause.
- No misalignment check at redirect time; it is caught on the next fetch_req.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum (IDLE, WAIT).
  - NOP_INSTR=32'h0000_0013.
  - err_cause constants (ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT).
  - Opcode constants shared with the control unit.
- One natural sub-module: fetch_timer. Saturating counter with clear/enable and an expired flag at TIMEOUT_CYCLES. Everything else stays inline.

Test Plan:
- Reset then fetch_req, imem_ready after 3 cycles with rdata=32'h00A00093 -> instr_valid pulse at cycle 4, instruction=32'h00A00093, instr_pc=0, pc=4.
- Zero-wait: ready in first WAIT cycle, two back-to-back fetches -> pc 0->4->8, two single-cycle instr_valid pulses.
- BNE: pc_write_cond=1, branch_op=1, alu_zero=0, target=64'h40 -> pc=64'h40. With alu_zero=1 -> pc unchanged.
- Redirect (pc_write=1, pc_src=1, target=64'h100) in the same cycle as imem_ready -> no instr_valid, instruction unchanged, pc=64'h100, imem_rd low next cycle.
- Memory never ready -> after 16 WAIT cycles imem_rd drops, fetch_err=1, err_cause=10. A later misaligned fetch leaves err_cause=10.
- Redirect to 64'h102 then fetch_req -> no imem_rd, fetch_err=1, err_cause=01. Reset mid-WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle RV64 core front end and control unit.
package core_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

    // Major opcodes decoded by the control unit
    localparam logic [6:0]  OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0]  OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0]  OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0]  OPC_STORE    = 7'b010_0011;
    localparam logic [6:0]  OPC_OP       = 7'b011_0011;
    localparam logic [6:0]  OPC_LUI      = 7'b011_0111;
    localparam logic [6:0]  OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0]  OPC_JALR     = 7'b110_0111;
    localparam logic [6:0]  OPC_JAL      = 7'b110_1111;

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait-cycle counter; o_expired marks the cycle in which the count reaches TIMEOUT_CYCLES.
module fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  MAX  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // r_count holds completed cycles, so the current cycle is the TIMEOUT_CYCLES-th one at LAST
    assign o_expired = i_enable && (r_count >= LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns PC and IR, handshakes with instruction memory, applies redirects.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN           = 64,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            branch_op,
    input  logic            pc_src,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instruction,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_busy,
    output logic            fetch_err,
    output logic [1:0]      err_cause
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_imem_addr;
    logic [31:0]     r_instruction;
    logic            r_instr_valid;
    logic            r_imem_rd;
    logic            r_fetch_err;
    logic [1:0]      r_err_cause;

    logic            w_cond_taken;
    logic            w_redirect;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_timer_clear;
    logic            w_timer_en;
    logic            w_expired;

    always_comb begin
        w_cond_taken  = pc_write_cond & (alu_zero ^ branch_op);
        w_redirect    = pc_write | w_cond_taken;
        w_pc_plus4    = r_pc + XLEN'(4);
        // A taken conditional branch always jumps to branch_target regardless of pc_src
        w_target      = (pc_src | w_cond_taken) ? branch_target : w_pc_plus4;
        w_timer_en    = (r_state == WAIT);
        w_timer_clear = (r_state == IDLE);
    end

    fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr_pc    <= RESET_PC;
            r_imem_addr   <= RESET_PC;
            r_instruction <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_imem_rd     <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_err_cause   <= ERR_NONE;
        end else begin
            r_instr_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end else if (fetch_req) begin
                        if (r_pc[1:0] == 2'b00) begin
                            r_state     <= WAIT;
                            r_imem_rd   <= 1'b1;
                            r_imem_addr <= r_pc;
                        end else begin
                            r_fetch_err <= 1'b1;
                            if (r_err_cause == ERR_NONE) r_err_cause <= ERR_MISALIGN;
                        end
                    end
                end
                WAIT: begin
                    // Redirect aborts the fetch and discards a same-cycle response
                    if (w_redirect) begin
                        r_pc      <= w_target;
                        r_state   <= IDLE;
                        r_imem_rd <= 1'b0;
                    end else if (imem_ready) begin
                        r_instruction <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_pc          <= w_pc_plus4;
                        r_instr_valid <= 1'b1;
                        r_state       <= IDLE;
                        r_imem_rd     <= 1'b0;
                    end else if (w_expired) begin
                        r_state     <= IDLE;
                        r_imem_rd   <= 1'b0;
                        r_fetch_err <= 1'b1;
                        if (r_err_cause == ERR_NONE) r_err_cause <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_imem_rd <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_imem_addr;
    assign imem_rd     = r_imem_rd;
    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign instr_pc    = r_instr_pc;
    assign fetch_busy  = (r_state == WAIT);
    assign fetch_err   = r_fetch_err;
    assign err_cause   = r_err_cause;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the fetch unit.
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_op;
    logic        pc_src;
    logic        alu_zero;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [63:0] instr_pc;
    logic        fetch_busy;
    logic        fetch_err;
    logic [1:0]  err_cause;

    instr_fetch_unit #(
        .XLEN           (64),
        .RESET_PC       (64'h0),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_op     (branch_op),
        .pc_src        (pc_src),
        .alu_zero      (alu_zero),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .instr_pc      (instr_pc),
        .fetch_busy    (fetch_busy),
        .fetch_err     (fetch_err),
        .err_cause     (err_cause)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a fetch is either outstanding or not, and counts how long it has waited.
    logic [63:0] m_pc, m_instr_pc, m_addr;
    logic [31:0] m_instr;
    bit          m_valid, m_busy, m_err;
    logic [1:0]  m_cause;
    int          m_waited;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_instr_pc = 64'h0; m_addr = 64'h0; m_instr = 32'h0000_0013;
        m_valid = 0; m_busy = 0; m_err = 0; m_cause = 2'b00; m_waited = 0;
    endtask

    task automatic model_fault(input logic [1:0] cause);
        if (!m_err) m_cause = cause;
        m_err = 1;
    endtask

    task automatic model_step();
        bit          taken;
        bit          redirect;
        logic [63:0] tgt;
        taken    = pc_write_cond && (alu_zero != branch_op);
        redirect = pc_write || taken;
        tgt      = (pc_src || taken) ? branch_target : m_pc + 64'd4;
        m_valid  = 0;
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (redirect) m_pc = tgt;
            else if (fetch_req) begin
                if (m_pc % 4 == 0) begin
                    m_busy = 1; m_waited = 0; m_addr = m_pc;
                end else model_fault(2'b01);
            end
        end else begin
            m_waited++;
            if (redirect) begin
                m_pc = tgt; m_busy = 0;
            end else if (imem_ready) begin
                m_instr = imem_rdata; m_instr_pc = m_pc; m_pc = m_pc + 64'd4;
                m_valid = 1; m_busy = 0;
            end else if (m_waited == TIMEOUT) begin
                m_busy = 0; model_fault(2'b10);
            end
        end
    endtask

    task automatic clear_inputs();
        reset = 0; fetch_req = 0; pc_write = 0; pc_write_cond = 0; branch_op = 0;
        pc_src = 0; alu_zero = 0; branch_target = 64'h0; imem_ready = 0; imem_rdata = 32'h0;
    endtask

    // Inputs are set by the caller beforehand; returns 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs(); reset = 1; step(); step(); reset = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, pc, 64'h0);
        chk({tag, "_instr_pc"}, instr_pc, 64'h0);
        chk({tag, "_instruction"}, {32'h0, instruction}, 64'h13);
        chk({tag, "_valid"}, {63'h0, instr_valid}, 64'h0);
        chk({tag, "_imem_rd"}, {63'h0, imem_rd}, 64'h0);
        chk({tag, "_busy"}, {63'h0, fetch_busy}, 64'h0);
        chk({tag, "_err"}, {61'h0, fetch_err, err_cause}, 64'h0);
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("pc", pc, m_pc);
                chk("instr_pc", instr_pc, m_instr_pc);
                chk("instruction", {32'h0, instruction}, {32'h0, m_instr});
                chk("instr_valid", {63'h0, instr_valid}, {63'h0, m_valid});
                chk("imem_rd", {63'h0, imem_rd}, {63'h0, m_busy});
                chk("fetch_busy", {63'h0, fetch_busy}, {63'h0, m_busy});
                chk("fetch_err", {63'h0, fetch_err}, {63'h0, m_err});
                chk("err_cause", {62'h0, err_cause}, {62'h0, m_cause});
                if (m_busy) chk("imem_addr", imem_addr, m_addr);
            end
        end
    end

    initial begin
        int rdy_pct;
        model_reset();
        clear_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        chk_en = 1'b1;
        check_reset_values("rst");

        // Fetch with ready on the third wait cycle
        fetch_req = 1; step();
        fetch_req = 0;
        chk("f1_rd", {63'h0, imem_rd}, 64'h1);
        step(); step();
        imem_ready = 1; imem_rdata = 32'h00A00093; step();
        imem_ready = 0;
        chk("f1_valid", {63'h0, instr_valid}, 64'h1);
        chk("f1_instr", {32'h0, instruction}, 64'h00A00093);
        chk("f1_instr_pc", instr_pc, 64'h0);
        chk("f1_pc", pc, 64'h4);
        step();
        chk("f1_valid_drop", {63'h0, instr_valid}, 64'h0);

        // Zero-wait back-to-back fetches
        do_reset();
        fetch_req = 1; step();
        fetch_req = 0; imem_ready = 1; imem_rdata = 32'h00100093; step();
        chk("zw_pc1", pc, 64'h4);
        chk("zw_v1", {63'h0, instr_valid}, 64'h1);
        imem_ready = 0; fetch_req = 1; step();
        chk("zw_v1_drop", {63'h0, instr_valid}, 64'h0);
        fetch_req = 0; imem_ready = 1; imem_rdata = 32'h00200113; step();
        imem_ready = 0;
        chk("zw_pc2", pc, 64'h8);
        chk("zw_instr2", {32'h0, instruction}, 64'h00200113);

        // BNE taken, then not taken
        pc_write_cond = 1; branch_op = 1; alu_zero = 0; branch_target = 64'h40; step();
        chk("bne_taken", pc, 64'h40);
        alu_zero = 1; branch_target = 64'h80; step();
        pc_write_cond = 0; branch_op = 0; alu_zero = 0;
        chk("bne_not_taken", pc, 64'h40);

        // Redirect in the same cycle as imem_ready
        fetch_req = 1; step();
        fetch_req = 0;
        pc_write = 1; pc_src = 1; branch_target = 64'h100; imem_ready = 1; imem_rdata = 32'hDEADBEEF; step();
        clear_inputs();
        chk("abort_valid", {63'h0, instr_valid}, 64'h0);
        chk("abort_instr", {32'h0, instruction}, 64'h00200113);
        chk("abort_pc", pc, 64'h100);
        chk("abort_rd", {63'h0, imem_rd}, 64'h0);

        // Timeout, then a later misaligned fetch keeps the first cause
        do_reset();
        fetch_req = 1; step();
        fetch_req = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("to_rd_held", {63'h0, imem_rd}, 64'h1);
        step();
        chk("to_rd_drop", {63'h0, imem_rd}, 64'h0);
        chk("to_err", {61'h0, fetch_err, err_cause}, {61'h0, 3'b110});
        pc_write = 1; pc_src = 1; branch_target = 64'h102; step();
        clear_inputs(); fetch_req = 1; step();
        fetch_req = 0;
        chk("to_mis_cause", {62'h0, err_cause}, 64'h2);

        // Misaligned fetch from a fresh reset, then reset mid-WAIT
        do_reset();
        pc_write = 1; pc_src = 1; branch_target = 64'h102; step();
        clear_inputs(); fetch_req = 1; step();
        fetch_req = 0;
        chk("mis_rd", {63'h0, imem_rd}, 64'h0);
        chk("mis_err", {61'h0, fetch_err, err_cause}, {61'h0, 3'b101});
        pc_write = 1; pc_src = 1; branch_target = 64'h200; step();
        clear_inputs(); fetch_req = 1; step();
        fetch_req = 0; reset = 1; imem_ready = 1; imem_rdata = 32'h12345678; step();
        clear_inputs();
        check_reset_values("midwait");

        // Randomised traffic
        rdy_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: rdy_pct = 3;
                    1: rdy_pct = 30;
                    default: rdy_pct = 80;
                endcase
            end
            reset         = ($urandom_range(0, 299) == 0);
            fetch_req     = $urandom_range(0, 1) == 1;
            pc_write      = ($urandom_range(0, 15) == 0);
            pc_write_cond = ($urandom_range(0, 7) == 0);
            branch_op     = $urandom_range(0, 1) == 1;
            alu_zero      = $urandom_range(0, 1) == 1;
            pc_src        = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0: branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
                1: branch_target = {$urandom, $urandom};
                default: branch_target = {32'h0, $urandom} & ~64'h3;
            endcase
            imem_ready = ($urandom_range(0, 99) < rdy_pct);
            imem_rdata = $urandom;
            step();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
